time_keeper: RTL and testbench

Time-of-day core of the alarm clock; sits directly downstream of the clock divider. It takes the divider's toggling output, converts each rising edge into a one-cycle tick, prescales ticks to 1 Hz, and maintains a 24-hour BCD hh:mm:ss count. The alarm comparator and display driver consume its time outputs and pulses. An adjust mode lets the user step hours and minutes.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/time_keeper_if.sv | 34 +++
 rtl/bcd_mod_counter.sv | 49 ++++
 rtl/time_keeper.sv | 133 +++++++++++++
 tb/tb_time_keeper.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock time-of-day path: digit width,
// field limits, default prescale ratio and the run/set mode encoding.
package clock_pkg;

    localparam int BCD_W             = 4;
    localparam int SEC_MAX           = 59;
    localparam int MIN_MAX           = 59;
    localparam int HR_MAX            = 23;
    localparam int EDGES_PER_SEC_DEF = 200;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_ONE  = 4'd1;
    localparam bcd_t BCD_NINE = 4'd9;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

    // Prescaler width; a ratio of 1 still needs a one-bit register.
    function automatic int pre_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Bundle of user controls, divider input and time/pulse outputs of the
// time keeper. The master side drives the inputs and observes the time.
interface time_keeper_if;
    import clock_pkg::*;

    logic div_in;
    logic adjust;
    logic inc_min;
    logic inc_hr;

    bcd_t hr_t;
    bcd_t hr_u;
    bcd_t min_t;
    bcd_t min_u;
    bcd_t sec_t;
    bcd_t sec_u;

    logic sec_pulse;
    logic min_pulse;
    logic day_pulse;

    modport master (
        output div_in, adjust, inc_min, inc_hr,
        input  hr_t, hr_u, min_t, min_u, sec_t, sec_u,
        input  sec_pulse, min_pulse, day_pulse
    );

    modport slave (
        input  div_in, adjust, inc_min, inc_hr,
        output hr_t, hr_u, min_t, min_u, sec_t, sec_u,
        output sec_pulse, min_pulse, day_pulse
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX back to 00. wrap flags the
// enabled step out of MAX so the caller can chain a carry. clr forces 00
// and wins over en.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output bcd_t tens,
    output bcd_t units,
    output logic wrap
);

    localparam bcd_t MAX_T = BCD_W'(MAX / 10);
    localparam bcd_t MAX_U = BCD_W'(MAX % 10);

    logic at_max;

    // Wrap on the full two-digit value so limits like 23 do not need to
    // pass through an illegal units value.
    assign at_max = (tens == MAX_T) && (units == MAX_U);
    assign wrap   = en & at_max;

    // Digit registers: reset/clear to 00, otherwise BCD increment on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            tens  <= BCD_ZERO;
            units <= BCD_ZERO;
        end else if (clr) begin
            tens  <= BCD_ZERO;
            units <= BCD_ZERO;
        end else if (en) begin
            if (at_max) begin
                tens  <= BCD_ZERO;
                units <= BCD_ZERO;
            end else if (units == BCD_NINE) begin
                tens  <= tens + BCD_ONE;
                units <= BCD_ZERO;
            end else begin
                units <= units + BCD_ONE;
            end
        end
    end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day core: turns divider edges into ticks, prescales them to
// seconds and drives three chained BCD counters for hh:mm:ss. In set mode
// the second/prescale path is frozen at zero and the user steps minutes
// and hours independently.
module time_keeper
    import clock_pkg::*;
#(
    parameter int EDGES_PER_SEC = EDGES_PER_SEC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    time_keeper_if.slave  bus
);

    localparam int               PRE_W    = pre_width(EDGES_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(EDGES_PER_SEC - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    mode_e            mode;
    logic             div_d;
    logic             tick;
    logic             sec_tick;
    logic [PRE_W-1:0] pre;

    logic sec_en;
    logic sec_clr;
    logic min_en;
    logic hr_en;
    logic sec_wrap;
    logic min_wrap;
    logic hr_wrap;

    assign mode = mode_e'(bus.adjust);

    // div_d resets low, so a divider that is already high out of reset
    // is seen as a rising edge.
    assign tick     = bus.div_in & ~div_d;
    assign sec_tick = (mode == MODE_RUN) && tick && (pre == PRE_LAST);

    // Divider edge-detect register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_d <= 1'b0;
        end else begin
            div_d <= bus.div_in;
        end
    end

    // Prescaler: counts ticks within the current second, held at 0 in set
    // mode so leaving set mode starts a full second.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (mode == MODE_SET) begin
            pre <= '0;
        end else if (tick) begin
            if (pre == PRE_LAST) begin
                pre <= '0;
            end else begin
                pre <= pre + PRE_ONE;
            end
        end
    end

    // Mode mux: run mode chains carries, set mode takes the user pulses
    // with no carry between minutes and hours.
    always_comb begin
        sec_en  = 1'b0;
        sec_clr = 1'b0;
        min_en  = 1'b0;
        hr_en   = 1'b0;
        case (mode)
            MODE_RUN: begin
                sec_en = sec_tick;
                min_en = sec_wrap;
                hr_en  = min_wrap;
            end
            MODE_SET: begin
                sec_clr = 1'b1;
                min_en  = bus.inc_min;
                hr_en   = bus.inc_hr;
            end
            default: begin
                sec_clr = 1'b0;
            end
        endcase
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_en),
        .clr   (sec_clr),
        .tens  (bus.sec_t),
        .units (bus.sec_u),
        .wrap  (sec_wrap)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en),
        .clr   (1'b0),
        .tens  (bus.min_t),
        .units (bus.min_u),
        .wrap  (min_wrap)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .clk   (clk),
        .rst   (rst),
        .en    (hr_en),
        .clr   (1'b0),
        .tens  (bus.hr_t),
        .units (bus.hr_u),
        .wrap  (hr_wrap)
    );

    // Pulses registered alongside the digits so they coincide with the new
    // value; the wraps only occur in run mode except hr_wrap, gated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sec_pulse <= 1'b0;
            bus.min_pulse <= 1'b0;
            bus.day_pulse <= 1'b0;
        end else begin
            bus.sec_pulse <= sec_tick;
            bus.min_pulse <= sec_wrap;
            bus.day_pulse <= hr_wrap && (mode == MODE_RUN);
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper with a 4-edge second: directed vector table,
// hand-written corner sequences and randomized traffic, all compared
// against a seconds-of-day reference model.
module tb_time_keeper;

    localparam int EPS = 4;

    logic clk;
    logic rst;
    time_keeper_if bus ();

    time_keeper #(.EDGES_PER_SEC(EPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time kept as seconds since midnight.
    int m_tod  = 0;
    int m_pre  = 0;
    bit m_prev = 1'b0;
    bit m_sp = 1'b0, m_mp = 1'b0, m_dp = 1'b0;

    typedef struct {
        bit r, d, a, im, ih;
        int hh, mm, ss;
        bit [2:0] p;
    } vec_t;

    vec_t vecs[13];

    task automatic model_step(input bit r, input bit d, input bit a,
                              input bit im, input bit ih);
        bit tk;
        int h, m, s;
        tk = d && !m_prev;
        m_sp = 1'b0; m_mp = 1'b0; m_dp = 1'b0;
        if (r) begin
            m_tod = 0; m_pre = 0; m_prev = 1'b0;
        end else begin
            h = m_tod / 3600;
            m = (m_tod / 60) % 60;
            s = m_tod % 60;
            if (a) begin
                s = 0;
                m_pre = 0;
                if (im) m = (m + 1) % 60;
                if (ih) h = (h + 1) % 24;
                m_tod = h * 3600 + m * 60 + s;
            end else if (tk) begin
                if (m_pre == EPS - 1) begin
                    m_pre = 0;
                    m_tod = (m_tod + 1) % 86400;
                    m_sp = 1'b1;
                    m_mp = (m_tod % 60) == 0;
                    m_dp = (m_tod == 0);
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            m_prev = d;
        end
    endtask

    function automatic logic [23:0] pack_time(input int hh, input int mm, input int ss);
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [26:0] dut_state();
        return {bus.hr_t, bus.hr_u, bus.min_t, bus.min_u, bus.sec_t, bus.sec_u,
                bus.sec_pulse, bus.min_pulse, bus.day_pulse};
    endfunction

    task automatic check_exp(input string name, input int hh, input int mm,
                             input int ss, input bit [2:0] p);
        logic [26:0] exp_v;
        logic [26:0] got_v;
        exp_v = {pack_time(hh, mm, ss), p};
        got_v = dut_state();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got time/pulses %h, expected %h", name, got_v, exp_v);
        end
    endtask

    task automatic check_pre0(input string name);
        checks++;
        if (dut.pre !== '0) begin
            errors++;
            $display("FAIL %s: pre got %0d, expected 0", name, dut.pre);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare on
    // the falling edge.
    task automatic step(input bit r, input bit d, input bit a,
                        input bit im, input bit ih);
        rst         = r;
        bus.div_in  = d;
        bus.adjust  = a;
        bus.inc_min = im;
        bus.inc_hr  = ih;
        @(posedge clk);
        model_step(r, d, a, im, ih);
        @(negedge clk);
        check_exp("model", m_tod / 3600, (m_tod / 60) % 60, m_tod % 60,
                  {m_sp, m_mp, m_dp});
    endtask

    task automatic edges(input int n, input bit a);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, a, 1'b0, 1'b0);
            step(1'b0, 1'b0, a, 1'b0, 1'b0);
        end
    endtask

    task automatic set_time(input int hh, input int mm);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < hh; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < mm; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        bit a_rand;
        rst = 1'b1;
        bus.div_in = 1'b0;
        bus.adjust = 1'b0;
        bus.inc_min = 1'b0;
        bus.inc_hr = 1'b0;

        // Reset with divider toggling, then the first counted second.
        vecs[0]  = '{1,1,0,0,0, 0,0,0, 3'b000};
        vecs[1]  = '{1,0,0,0,0, 0,0,0, 3'b000};
        vecs[2]  = '{1,1,0,0,0, 0,0,0, 3'b000};
        vecs[3]  = '{0,0,0,0,0, 0,0,0, 3'b000};
        vecs[4]  = '{0,1,0,0,0, 0,0,0, 3'b000};
        vecs[5]  = '{0,0,0,0,0, 0,0,0, 3'b000};
        vecs[6]  = '{0,1,0,0,0, 0,0,0, 3'b000};
        vecs[7]  = '{0,0,0,0,0, 0,0,0, 3'b000};
        vecs[8]  = '{0,1,0,0,0, 0,0,0, 3'b000};
        vecs[9]  = '{0,0,0,0,0, 0,0,0, 3'b000};
        vecs[10] = '{0,1,0,0,0, 0,0,1, 3'b100};
        vecs[11] = '{0,0,0,0,0, 0,0,1, 3'b000};
        vecs[12] = '{0,0,0,0,0, 0,0,1, 3'b000};

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].r, vecs[i].d, vecs[i].a, vecs[i].im, vecs[i].ih);
            check_exp($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].p);
            if (i == 2) check_pre0("reset_pre");
        end

        // Day wrap from 23:59:58.
        set_time(23, 59);
        edges(58 * EPS, 1'b0);
        check_exp("preload", 23, 59, 58, 3'b000);
        edges(EPS - 1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_exp("to_59", 23, 59, 59, 3'b100);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        edges(EPS - 1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_exp("day_wrap", 0, 0, 0, 3'b111);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_exp("day_wrap_after", 0, 0, 0, 3'b000);

        // Set mode from 10:59:30.
        set_time(10, 59);
        edges(30 * EPS, 1'b0);
        check_exp("at_10_59_30", 10, 59, 30, 3'b000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_exp("set_ss0", 10, 59, 0, 3'b000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_exp("set_min_wrap", 10, 0, 0, 3'b000);
        for (int i = 0; i < 14; i++) step(1'b0, (i % 2) == 0, 1'b1, 1'b0, 1'b1);
        check_exp("set_hr_wrap", 0, 0, 0, 3'b000);
        edges(2 * EPS, 1'b1);
        check_exp("set_ticks_ignored", 0, 0, 0, 3'b000);
        edges(EPS - 1, 1'b0);
        check_exp("resume_partial", 0, 0, 0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_exp("resume_first_sec", 0, 0, 1, 3'b100);

        // Simultaneous set pulses, then ignored in run mode.
        set_time(5, 7);
        check_exp("at_05_07", 5, 7, 0, 3'b000);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_exp("both_set", 6, 8, 0, 3'b000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_exp("both_run_ignored", 6, 8, 0, 3'b000);

        // Mid-second reset restarts the prescaler.
        edges(2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_exp("mid_rst", 0, 0, 0, 3'b000);
        check_pre0("mid_rst_pre");
        edges(EPS - 1, 1'b0);
        check_exp("mid_rst_partial", 0, 0, 0, 3'b000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_exp("mid_rst_sec", 0, 0, 1, 3'b100);

        // Randomized traffic against the model.
        a_rand = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) a_rand = ~a_rand;
            step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), a_rand,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
